// File: rtl/nonce_disp_pkg.sv
// Shared types and constants for the nonce dispatcher.
//   nd_state_t  : dispatcher FSM state (IDLE / RUN / DONE)
//   NONCE_W_DEF : default nonce width
//   sel_width() : width of a core index (minimum 1 bit so a single-core build still has a port)
package nonce_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } nd_state_t;

  localparam int NONCE_W_DEF = 32;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nonce_dispatcher_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       in   N        request vector
//   ptr       in   W        highest-priority index this cycle (must be < N)
//   gnt_valid out  1        at least one request present
//   gnt_idx   out  W        first requesting index at or after ptr, wrapping modulo N
module rr_arbiter
  import nonce_disp_pkg::*;
#(
  parameter int N = 4,
  localparam int W = sel_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx
);

  int k;

  // Walk offsets from the farthest to the nearest so the nearest requester
  // (lowest offset from ptr) is the last one written and therefore wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    k         = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % N;
      if (req[k]) begin
        gnt_valid = 1'b1;
        gnt_idx   = W'(k);
      end
    end
  end

endmodule

// File: rtl/nonce_dispatcher.sv
// Nonce dispatcher: issues START, START+STEP, ... up to an inclusive run-time
// limit, handing each nonce to one of NUM_CORES hash cores by round robin.
// Optional feature macro: NONCE_DISP_STATS_EN (enables the issued_cnt counter;
// without it issued_cnt is tied to zero).
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   enable       allow issuing; low holds position
//   restart      synchronous rewind to START, clears done/overflow
//   range_end    inclusive last nonce, sampled every cycle
//   core_ready   per-core ready
//   nonce        registered issued nonce (holds between issues)
//   nonce_valid  one-cycle pulse per issue
//   core_sel     destination core of the issued nonce
//   done         range exhausted (sticky)
//   overflow     exhaustion caused by nonce wrap (sticky)
//   issued_cnt   saturating issue count since reset/restart
//   fsm_state    current FSM state, for observation
// Handshake: a nonce is transferred to core k on a clock edge where the
// dispatcher is in RUN, enable is high, core_ready[k] is high and k is the
// round-robin grant; the transfer is reported in the following cycle by
// nonce_valid=1 with core_sel=k. There is no back-pressure after the edge.
module nonce_dispatcher
  import nonce_disp_pkg::*;
#(
  parameter int                   NONCE_W   = NONCE_W_DEF,
  parameter int                   NUM_CORES = 4,
  parameter logic [NONCE_W-1:0]   START     = '0,
  parameter logic [NONCE_W-1:0]   STEP      = 1,
  localparam int                  SEL_W     = sel_width(NUM_CORES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 restart,
  input  logic [NONCE_W-1:0]   range_end,
  input  logic [NUM_CORES-1:0] core_ready,
  output logic [NONCE_W-1:0]   nonce,
  output logic                 nonce_valid,
  output logic [SEL_W-1:0]     core_sel,
  output logic                 done,
  output logic                 overflow,
  output logic [NONCE_W-1:0]   issued_cnt,
  output nd_state_t            fsm_state
);

  nd_state_t          state, state_next;
  logic [NONCE_W-1:0] cur;
  logic [SEL_W-1:0]   rr_ptr, ptr_next;
  logic               gnt_valid;
  logic [SEL_W-1:0]   gnt_idx;
  logic [NONCE_W:0]   nxt;
  logic               in_range, wrap, past_end;
  logic               issue, finish;

  rr_arbiter #(.N(NUM_CORES)) u_arb (
    .req       (core_ready),
    .ptr       (rr_ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // One extra bit catches the wrap past all-ones.
  assign nxt      = {1'b0, cur} + {1'b0, STEP};
  assign wrap     = nxt[NONCE_W];
  assign past_end = nxt[NONCE_W-1:0] > range_end;
  assign in_range = cur <= range_end;
  assign ptr_next = (gnt_idx == SEL_W'(NUM_CORES - 1)) ? '0 : gnt_idx + 1'b1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; restart overrides every transition.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = RUN;
      RUN:     if (finish) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
    if (restart) state_next = IDLE;
  end

  // Output/control decode. A lowered limit (cur beyond range_end) ends the
  // run even while enable is low, without issuing.
  always_comb begin
    issue  = (state == RUN) && enable && gnt_valid && in_range && !restart;
    finish = (state == RUN) && !restart &&
             (!in_range || (issue && (wrap || past_end)));
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cur         <= START;
      rr_ptr      <= '0;
      nonce       <= '0;
      nonce_valid <= 1'b0;
      core_sel    <= '0;
      done        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      nonce_valid <= issue;
      if (restart) begin
        cur      <= START;
        rr_ptr   <= '0;
        done     <= 1'b0;
        overflow <= 1'b0;
      end else begin
        if (issue) begin
          nonce    <= cur;
          core_sel <= gnt_idx;
          cur      <= nxt[NONCE_W-1:0];
          rr_ptr   <= ptr_next;
        end
        if (finish) begin
          done     <= 1'b1;
          overflow <= issue && wrap;
        end
      end
    end
  end

`ifdef NONCE_DISP_STATS_EN
  logic [NONCE_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || restart)          cnt <= '0;
    else if (issue && cnt != '1) cnt <= cnt + 1'b1;
  end

  assign issued_cnt = cnt;
`else
  assign issued_cnt = '0;
`endif

  assign fsm_state = state;

endmodule

// File: tb/tb_nonce_dispatcher.sv
module tb_nonce_dispatcher;
  import nonce_disp_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  // ---------------- DUT A: defaults ----------------
  logic        en_a = 1'b0, rs_a = 1'b0;
  logic [31:0] re_a = '0;
  logic [3:0]  rdy_a = '0;
  logic [31:0] nonce_a, cnt_a;
  logic        valid_a, done_a, ovf_a;
  logic [1:0]  sel_a;
  nd_state_t   st_a;

  nonce_dispatcher dut_a (
    .clk(clk), .rst(rst), .enable(en_a), .restart(rs_a), .range_end(re_a),
    .core_ready(rdy_a), .nonce(nonce_a), .nonce_valid(valid_a), .core_sel(sel_a),
    .done(done_a), .overflow(ovf_a), .issued_cnt(cnt_a), .fsm_state(st_a)
  );

  // ---------------- DUT B: start near wrap ----------------
  logic        en_b = 1'b0;
  logic [31:0] nonce_b, cnt_b;
  logic        valid_b, done_b, ovf_b;
  logic [1:0]  sel_b;
  nd_state_t   st_b;

  nonce_dispatcher #(.START(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .rst(rst), .enable(en_b), .restart(1'b0), .range_end(32'hFFFF_FFFF),
    .core_ready(4'hF), .nonce(nonce_b), .nonce_valid(valid_b), .core_sel(sel_b),
    .done(done_b), .overflow(ovf_b), .issued_cnt(cnt_b), .fsm_state(st_b)
  );

  // ---------------- DUT C: step 3 ----------------
  logic        en_c = 1'b0;
  logic [31:0] nonce_c, cnt_c;
  logic        valid_c, done_c, ovf_c;
  logic [1:0]  sel_c;
  nd_state_t   st_c;

  nonce_dispatcher #(.STEP(32'd3)) dut_c (
    .clk(clk), .rst(rst), .enable(en_c), .restart(1'b0), .range_end(32'd10),
    .core_ready(4'hF), .nonce(nonce_c), .nonce_valid(valid_c), .core_sel(sel_c),
    .done(done_c), .overflow(ovf_c), .issued_cnt(cnt_c), .fsm_state(st_c)
  );

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] got_b[$], got_c[$], exp_q[$];
  bit collect_bc = 1'b1;

  always @(negedge clk) begin
    if (collect_bc) begin
      if (valid_b) got_b.push_back(nonce_b);
      if (valid_c) got_c.push_back(nonce_c);
    end
  end

  task automatic chk(input string name, input longint got, input longint exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model for DUT A ----------------
  // Tracks "has been enabled since reset/restart" and "range finished" as
  // plain flags; cur kept in 64-bit arithmetic so a wrap shows up as >= 2**32.
  bit     m_armed, m_fin, m_valid, m_ovf;
  longint m_cur, m_nonce, m_cnt;
  int     m_ptr, m_sel;

  task automatic model_step(input bit r, input bit e, input bit s,
                            input logic [31:0] re, input logic [3:0] rdy);
    longint lim, nx;
    bit found;
    lim = longint'(re);
    if (r) begin
      m_armed = 0; m_fin = 0; m_cur = 0; m_ptr = 0; m_nonce = 0;
      m_valid = 0; m_sel = 0; m_ovf = 0; m_cnt = 0;
    end else begin
      m_valid = 0;
      if (s) begin
        m_armed = 0; m_fin = 0; m_cur = 0; m_ptr = 0; m_ovf = 0; m_cnt = 0;
      end else if (!m_armed) begin
        if (e) m_armed = 1;
      end else if (!m_fin) begin
        if (lim < m_cur) begin
          m_fin = 1;
        end else if (e && rdy != 0) begin
          found = 0;
          for (int off = 0; off < 4; off++) begin
            if (!found && rdy[(m_ptr + off) % 4]) begin
              found = 1;
              m_sel = (m_ptr + off) % 4;
            end
          end
          m_valid = 1;
          m_nonce = m_cur;
          m_ptr   = (m_sel + 1) % 4;
          if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
          nx = m_cur + 1;
          if (nx > 64'hFFFF_FFFF) begin
            m_fin = 1; m_ovf = 1;
          end else if (nx > lim) begin
            m_fin = 1;
          end
          m_cur = nx & 64'hFFFF_FFFF;
        end
      end
    end
  endtask

  function automatic longint exp_cnt_of(input longint c);
`ifdef NONCE_DISP_STATS_EN
    return c;
`else
    return 0;
`endif
  endfunction

  task automatic check_model(input string name);
    nd_state_t es;
    longint ec;
    es = m_fin ? DONE : (m_armed ? RUN : IDLE);
    ec = exp_cnt_of(m_cnt);
    vectors++;
    if (valid_a !== m_valid || nonce_a !== 32'(m_nonce) || sel_a !== 2'(m_sel) ||
        done_a !== m_fin || ovf_a !== m_ovf || cnt_a !== 32'(ec) || st_a !== es) begin
      miscompares++;
      $display("FAIL %s: got v=%0b n=%0h s=%0d d=%0b o=%0b c=%0h st=%0d expected v=%0b n=%0h s=%0d d=%0b o=%0b c=%0h st=%0d",
               name, valid_a, nonce_a, sel_a, done_a, ovf_a, cnt_a, st_a,
               m_valid, m_nonce, m_sel, m_fin, m_ovf, ec, es);
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit r, input bit e, input bit s,
                       input logic [31:0] re, input logic [3:0] rdy);
    rst = r; en_a = e; rs_a = s; re_a = re; rdy_a = rdy;
    @(posedge clk);
    model_step(r, e, s, re, rdy);
    #1;
  endtask

  // ---------------- table for the basic 0..7 run ----------------
  typedef struct {
    logic        exp_valid;
    logic [31:0] exp_nonce;
    logic [1:0]  exp_sel;
    logic        exp_done;
    logic [31:0] exp_cnt;
  } vec_t;
  vec_t tbl[11];

  initial begin
    longint last, exp_next;
    int exp_sel, n;
    bit ok;
    logic [31:0] re;

    for (int i = 0; i < 11; i++) begin
      int last_issued;
      last_issued     = (i - 1 > 7) ? 7 : i - 1;
      tbl[i].exp_valid = (i >= 1 && i <= 8);
      tbl[i].exp_nonce = (i >= 1) ? 32'(last_issued) : 32'd0;
      tbl[i].exp_sel   = (i >= 1) ? 2'(last_issued % 4) : 2'd0;
      tbl[i].exp_done  = (i >= 8);
      tbl[i].exp_cnt   = 32'(exp_cnt_of((i > 8) ? 8 : i));
    end

    // Reset: two cycles
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check_model("reset");
    chk("reset_nonce", nonce_a, 0);
    chk("reset_done", done_a, 0);
    en_b = 1'b1; en_c = 1'b1;

    // Full-ready run 0..7: first edge arms, eight issues, then idle in DONE
    for (int i = 0; i < 11; i++) begin
      cycle(0, 1, 0, 7, 4'hF);
      vectors++;
      if (valid_a !== tbl[i].exp_valid || nonce_a !== tbl[i].exp_nonce ||
          sel_a !== tbl[i].exp_sel || done_a !== tbl[i].exp_done ||
          ovf_a !== 1'b0 || cnt_a !== tbl[i].exp_cnt) begin
        miscompares++;
        $display("FAIL table[%0d]: got v=%0b n=%0h s=%0d d=%0b o=%0b c=%0h expected v=%0b n=%0h s=%0d d=%0b o=0 c=%0h",
                 i, valid_a, nonce_a, sel_a, done_a, ovf_a, cnt_a, tbl[i].exp_valid,
                 tbl[i].exp_nonce, tbl[i].exp_sel, tbl[i].exp_done, tbl[i].exp_cnt);
      end
      check_model("table_model");
    end

    // Wrap near all-ones and step-3 runs
    collect_bc = 1'b0;
    en_b = 1'b0; en_c = 1'b0;
    exp_q = {32'hFFFF_FFFC, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    chk("wrap_count", got_b.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_b.size(); i++) chk("wrap_nonce", got_b[i], exp_q[i]);
    chk("wrap_done", done_b, 1);
    chk("wrap_overflow", ovf_b, 1);
    exp_q = {32'd0, 32'd3, 32'd6, 32'd9};
    chk("step3_count", got_c.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_c.size(); i++) chk("step3_nonce", got_c[i], exp_q[i]);
    chk("step3_done", done_c, 1);
    chk("step3_overflow", ovf_c, 0);

    // Restart clears done and the issue count
    cycle(0, 0, 1, 7, 4'hF);
    check_model("restart_clear");
    chk("restart_cnt", cnt_a, 0);
    chk("restart_done", done_a, 0);

    // Single ready core, then alternating pair
    cycle(1, 0, 0, 0, 0);
    last = -1;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 0, 100, 4'b0100);
      check_model("single_core");
      if (valid_a) begin
        chk("single_sel", sel_a, 2);
        chk("single_incr", nonce_a, last + 1);
        last = nonce_a;
      end
    end
    exp_sel = 3;
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, 0, 100, 4'b1010);
      check_model("pair_cores");
      if (valid_a) begin
        chk("pair_sel", sel_a, exp_sel);
        exp_sel = (exp_sel == 3) ? 1 : 3;
      end
    end

    // Restart after nonce 5, then enable gap mid-run
    cycle(1, 0, 0, 0, 0);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      cycle(0, 1, 0, 100, 4'hF);
      check_model("pre_restart");
      if (valid_a && nonce_a == 5) ok = 1;
    end
    chk("reach_nonce5", ok, 1);
    cycle(0, 1, 1, 100, 4'hF);
    check_model("restart_cycle");
    chk("restart_no_valid", valid_a, 0);
    chk("restart_idle", st_a, IDLE);
    cycle(0, 1, 0, 100, 4'hF);
    chk("rearm_no_valid", valid_a, 0);
    cycle(0, 1, 0, 100, 4'hF);
    chk("first_after_restart_valid", valid_a, 1);
    chk("first_after_restart_nonce", nonce_a, 0);
    chk("first_after_restart_sel", sel_a, 0);
    exp_next = 1;
    for (int i = 0; i < 9; i++) begin
      cycle(0, (i < 2 || i >= 5), 0, 100, 4'hF);
      check_model("enable_gap");
      if (valid_a) begin
        chk("gap_nonce", nonce_a, exp_next);
        exp_next++;
      end
    end
    chk("gap_total", exp_next, 7);

    // Limit lowered below cur mid-run
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 20, 4'hF);
    chk("lower_pre_nonce", nonce_a, 3);
    cycle(0, 1, 0, 2, 4'hF);
    check_model("lower_limit");
    chk("lower_done", done_a, 1);
    chk("lower_no_valid", valid_a, 0);
    chk("lower_no_overflow", ovf_a, 0);

    // Randomized run against the model
    cycle(1, 0, 0, 0, 0);
    re = 40;
    n = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 24) == 0) re = $urandom_range(0, 80);
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
            $urandom_range(0, 29) == 0, re, 4'($urandom_range(0, 15)));
      check_model("random");
      if (valid_a) n++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
